// File: rtl/fp4_pkg.sv
// Shared E2M1 (FP4) definitions: operand layout, half-unit magnitude table, FSM states,
// and the quarter-unit fixed-point to E2M1 rounding used by the accumulator and writeback.
package fp4_pkg;

    typedef struct packed {
        logic       sign;
        logic [1:0] exp;
        logic       man;
    } e2m1_t;

    // Magnitude of each {exp,man} code in half-units: 0, .5, 1, 1.5, 2, 3, 4, 6.
    localparam logic [3:0] FP4_MAG_LUT [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd12};

    typedef enum logic [1:0] {
        ACC,
        FLUSH,
        DONE
    } fsm_e;

    // Input is in quarter-units. Breakpoints are the midpoints between representable values;
    // a midpoint goes to the neighbour whose mantissa bit is 0.
    function automatic e2m1_t fixed_to_e2m1(input logic signed [63:0] value);
        logic [63:0] mag;
        logic [2:0]  code;
        mag = value[63] ? -value : value;
        if      (mag <= 64'd1)  code = 3'd0;
        else if (mag == 64'd2)  code = 3'd1;
        else if (mag <= 64'd5)  code = 3'd2;
        else if (mag == 64'd6)  code = 3'd3;
        else if (mag <= 64'd10) code = 3'd4;
        else if (mag <= 64'd13) code = 3'd5;
        else if (mag <= 64'd20) code = 3'd6;
        else                    code = 3'd7;
        // A value that rounds to zero is always returned as +0.
        return '{sign: value[63] && (code != 3'd0), exp: code[2:1], man: code[0]};
    endfunction

endpackage

// File: rtl/fp4_e2m1_mul.sv
// Single-lane E2M1 x E2M1 multiplier; result is a signed 9-bit value in quarter-units.
module fp4_e2m1_mul
    import fp4_pkg::*;
(
    input  logic [3:0]        a,
    input  logic [3:0]        b,
    output logic signed [8:0] prod
);

    e2m1_t      ea;
    e2m1_t      eb;
    logic [7:0] mag;
    logic       neg;

    assign ea  = a;
    assign eb  = b;
    // half-units x half-units = quarter-units; largest product is 12*12 = 144
    assign mag = 8'(FP4_MAG_LUT[{ea.exp, ea.man}]) * 8'(FP4_MAG_LUT[{eb.exp, eb.man}]);
    // A zero magnitude never carries a sign, so -0 operands behave as 0.
    assign neg  = (ea.sign ^ eb.sign) && (mag != 8'd0);
    assign prod = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});

endmodule

// File: rtl/fp4_dot_accumulator.sv
// Multi-lane FP4 dot-product MAC with a two-stage pipeline and valid/ready result port.
// Build option FP4_ACC_SAT_EN: accumulator saturates on overflow instead of wrapping.
module fp4_dot_accumulator
    import fp4_pkg::*;
#(
    parameter int LANES = 4,
    parameter int ACC_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [4*LANES-1:0] i_a,
    input  logic [4*LANES-1:0] i_b,
    input  logic               i_last,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [ACC_W-1:0]   o_acc,
    output logic [3:0]         o_fp4,
    output logic               o_ovf
);

    localparam int LSUM_W = 9 + $clog2(LANES);

    logic signed [8:0]        prod [LANES];
    logic signed [LSUM_W-1:0] lane_sum;

    logic                     ready_en;
    logic                     s1_valid;
    logic                     s1_last;
    logic signed [LSUM_W-1:0] s1_sum;
    logic                     closing;

    logic signed [ACC_W-1:0]  acc;
    logic                     ovf;
    logic signed [ACC_W:0]    acc_sum;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     step_ovf;
    e2m1_t                    acc_fp4;

    fsm_e                     state;
    fsm_e                     state_next;
    logic                     accept;
    logic                     consume;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        fp4_e2m1_mul u_mul (
            .a    (i_a[4*k +: 4]),
            .b    (i_b[4*k +: 4]),
            .prod (prod[k])
        );
    end

    always_comb begin
        lane_sum = '0;
        // NOTE: blocking assignment is intended here; the loop accumulates through lane_sum
        // within a single evaluation, which non-blocking assignment cannot express.
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + LSUM_W'(prod[k]);
        end
    end

    // One guard bit above the accumulator exposes signed overflow of each step.
    always_comb begin
        acc_sum  = (ACC_W+1)'(acc) + (ACC_W+1)'(s1_sum);
        step_ovf = acc_sum[ACC_W] != acc_sum[ACC_W-1];
`ifdef FP4_ACC_SAT_EN
        if (step_ovf) begin
            acc_next = acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_next = acc_sum[ACC_W-1:0];
        end
`else
        acc_next = acc_sum[ACC_W-1:0];
`endif
    end

    assign acc_fp4 = fixed_to_e2m1(64'(acc));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before the case so that no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        case (state)
            ACC: begin
                o_ready = ready_en;
                if (i_valid && ready_en && i_last) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (closing) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_next = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end

    assign accept  = i_valid & o_ready;
    assign consume = o_valid & i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_en <= 1'b0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= '0;
            closing  <= 1'b0;
            acc      <= '0;
            ovf      <= 1'b0;
            o_acc    <= '0;
            o_fp4    <= '0;
            o_ovf    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            s1_valid <= accept;
            if (accept) begin
                s1_sum  <= lane_sum;
                s1_last <= i_last;
            end
            // closing marks the cycle after S2 folded in the final beat of the dot product.
            closing <= s1_valid & s1_last;
            if (consume) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (s1_valid) begin
                acc <= acc_next;
                ovf <= ovf | step_ovf;
            end
            if (closing) begin
                o_acc <= acc;
                o_fp4 <= acc_fp4;
                o_ovf <= ovf;
            end
        end
    end

    a_hold_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_valid && !i_ready) |=> ($stable(o_acc) && $stable(o_fp4) && $stable(o_ovf) && o_valid));

    a_no_overlap: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(o_valid && o_ready));

endmodule

// File: tb/tb_fp4_dot_accumulator.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and random dot products.
module tb_fp4_dot_accumulator;

    localparam int LANES = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        last;
    logic        ready;
    logic [15:0] a;
    logic [15:0] b;

    logic        ready16, valid16, ovf16;
    logic [15:0] acc16;
    logic [3:0]  fp16;
    logic        ready12, valid12, ovf12;
    logic [11:0] acc12;
    logic [3:0]  fp12;

    always #5 clk = ~clk;

    fp4_dot_accumulator #(.LANES(LANES), .ACC_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready16),
        .i_a(a), .i_b(b), .i_last(last), .o_valid(valid16), .i_ready(ready),
        .o_acc(acc16), .o_fp4(fp16), .o_ovf(ovf16)
    );

    fp4_dot_accumulator #(.LANES(LANES), .ACC_W(12)) dut12 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready12),
        .i_a(a), .i_b(b), .i_last(last), .o_valid(valid12), .i_ready(ready),
        .o_acc(acc12), .o_fp4(fp12), .o_ovf(ovf12)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] beat_a[$];
    logic [15:0] beat_b[$];
    bit          gaps;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        longint      acc;
        logic [3:0]  fp4;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic real fp4_val(input logic [3:0] c);
        real m;
        case (c[2:0])
            3'd0: m = 0.0;
            3'd1: m = 0.5;
            3'd2: m = 1.0;
            3'd3: m = 1.5;
            3'd4: m = 2.0;
            3'd5: m = 3.0;
            3'd6: m = 4.0;
            default: m = 6.0;
        endcase
        return c[3] ? -m : m;
    endfunction

    // Exact real-valued dot product per beat, accumulated with range handling for width w.
    task automatic model_acc(input int w, output longint acc, output bit ovf);
        longint hi, lo, span;
        real    s;
        hi   = (longint'(1) << (w - 1)) - 1;
        lo   = -(longint'(1) << (w - 1));
        span = longint'(1) << w;
        acc  = 0;
        ovf  = 1'b0;
        foreach (beat_a[i]) begin
            s = 0.0;
            for (int k = 0; k < LANES; k++) begin
                s += fp4_val(beat_a[i][4*k +: 4]) * fp4_val(beat_b[i][4*k +: 4]);
            end
            acc += longint'(s * 4.0);
            if (acc > hi || acc < lo) begin
                ovf = 1'b1;
`ifdef FP4_ACC_SAT_EN
                acc = (acc > hi) ? hi : lo;
`else
                acc = (acc > hi) ? acc - span : acc + span;
`endif
            end
        end
    endtask

    // Nearest representable value by distance search; ties go to the even code (man=0).
    function automatic logic [3:0] model_fp4(input longint acc);
        real x, d, best_d;
        int  best;
        x      = real'(acc < 0 ? -acc : acc) / 4.0;
        best   = 0;
        best_d = x;
        for (int i = 1; i < 8; i++) begin
            d = x - fp4_val(4'(i));
            if (d < 0.0) d = -d;
            if (d < best_d || (d == best_d && (i % 2) == 0)) begin
                best   = i;
                best_d = d;
            end
        end
        return {(acc < 0) && (best != 0), 3'(best)};
    endfunction

    task automatic run_dot(input string name, input int hold, input bit use_exp,
                           input longint e16, input logic [3:0] f16, input bit o16,
                           input longint e12, input logic [3:0] f12, input bit o12);
        longint     x16, x12;
        bit         v16, v12;
        logic [3:0] y16, y12;
        int         k;
        if (use_exp) begin
            x16 = e16; y16 = f16; v16 = o16;
            x12 = e12; y12 = f12; v12 = o12;
        end else begin
            model_acc(16, x16, v16);
            model_acc(12, x12, v12);
            y16 = model_fp4(x16);
            y12 = model_fp4(x12);
        end
        foreach (beat_a[i]) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                valid = 1'b0;
                a     = 16'($urandom);
                b     = 16'($urandom);
                last  = 1'($urandom);
                @(negedge clk);
            end
            valid = 1'b1;
            a     = beat_a[i];
            b     = beat_b[i];
            last  = (i == beat_a.size() - 1);
            k     = 0;
            while (!ready16 && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (!ready16) begin
                check({name, " ready_timeout"}, 0, 1);
                valid = 1'b0;
                return;
            end
            @(posedge clk);
            if (!last) @(negedge clk);
        end
        k = 0;
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
        while (!valid16 && k < 10) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        check({name, " latency"}, k, 2);
        check({name, " acc16"}, longint'($signed(acc16)), x16);
        check({name, " fp4_16"}, fp16, y16);
        check({name, " ovf16"}, ovf16, v16);
        check({name, " acc12"}, longint'($signed(acc12)), x12);
        check({name, " fp4_12"}, fp12, y12);
        check({name, " ovf12"}, ovf12, v12);
        for (int h = 0; h < hold; h++) begin
            valid = 1'b1;
            a     = 16'($urandom);
            b     = 16'($urandom);
            last  = 1'($urandom);
            @(negedge clk);
            check({name, " hold_valid"}, valid16, 1);
            check({name, " hold_ready"}, ready16, 0);
            check({name, " hold_acc"}, longint'($signed(acc16)), x16);
            check({name, " hold_fp4"}, fp16, y16);
        end
        valid = 1'b0;
        last  = 1'b0;
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready = 1'b0;
        check({name, " released"}, {valid16, ready16}, 2'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        last  = 1'b0;
        ready = 1'b0;
        a     = '0;
        b     = '0;
        gaps  = 1'b0;

        vecs[0]  = '{16'h2222, 16'h3333,   24, 4'h7};
        vecs[1]  = '{16'h7F00, 16'h2200,    0, 4'h0};
        vecs[2]  = '{16'h2100, 16'h4200,   10, 4'h4};
        vecs[3]  = '{16'hA900, 16'h2100,   -5, 4'hA};
        vecs[4]  = '{16'h8888, 16'h7777,    0, 4'h0};
        vecs[5]  = '{16'h7777, 16'h7777,  576, 4'h7};
        vecs[6]  = '{16'hFFFF, 16'h7777, -576, 4'hF};
        vecs[7]  = '{16'h0001, 16'h0001,    1, 4'h0};
        vecs[8]  = '{16'h0009, 16'h0001,   -1, 4'h0};
        vecs[9]  = '{16'h0001, 16'h0003,    3, 4'h2};
        vecs[10] = '{16'h0021, 16'h0021,    5, 4'h2};
        vecs[11] = '{16'h0062, 16'h0022,   20, 4'h6};
        vecs[12] = '{16'h0052, 16'h0021,   14, 4'h6};

        repeat (2) @(negedge clk);
        check("reset o_valid", valid16, 0);
        check("reset o_acc", acc16, 0);
        check("reset o_fp4", fp16, 0);
        check("reset o_ovf", ovf16, 0);
        check("reset o_ready", ready16, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after reset", ready16, 1);

        for (int i = 0; i < 13; i++) begin
            beat_a = '{vecs[i].a};
            beat_b = '{vecs[i].b};
            run_dot($sformatf("vec%0d", i), (i == 0) ? 5 : 0, 1'b1,
                    vecs[i].acc, vecs[i].fp4, 1'b0, vecs[i].acc, vecs[i].fp4, 1'b0);
        end

        beat_a = '{16'h7777, 16'h7777, 16'h7777, 16'h7777};
        beat_b = '{16'h7777, 16'h7777, 16'h7777, 16'h7777};
`ifdef FP4_ACC_SAT_EN
        run_dot("ovf", 0, 1'b1, 2304, 4'h7, 1'b0, 2047, 4'h7, 1'b1);
`else
        run_dot("ovf", 0, 1'b1, 2304, 4'h7, 1'b0, -1792, 4'hF, 1'b1);
`endif
        beat_a.push_back(16'hFFFF);
        beat_b.push_back(16'h7777);
`ifdef FP4_ACC_SAT_EN
        run_dot("ovf_cont", 0, 1'b1, 1728, 4'h7, 1'b0, 1471, 4'h7, 1'b1);
`else
        run_dot("ovf_cont", 0, 1'b1, 1728, 4'h7, 1'b0, 1728, 4'h7, 1'b1);
`endif

        valid = 1'b1;
        a     = 16'h7777;
        b     = 16'h7777;
        last  = 1'b0;
        repeat (2) @(negedge clk);
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midacc reset o_valid", valid16, 0);
        check("midacc reset o_acc16", acc16, 0);
        check("midacc reset o_acc12", acc12, 0);
        check("midacc reset o_ovf12", ovf12, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midacc ready after reset", ready16, 1);
        beat_a = '{16'h2222};
        beat_b = '{16'h3333};
        run_dot("post_reset", 0, 1'b1, 24, 4'h7, 1'b0, 24, 4'h7, 1'b0);

        gaps = 1'b1;
        for (int t = 0; t < 40; t++) begin
            beat_a.delete();
            beat_b.delete();
            repeat ($urandom_range(1, 6)) begin
                beat_a.push_back(16'($urandom));
                beat_b.push_back(16'($urandom));
            end
            run_dot($sformatf("rnd%0d", t), $urandom_range(0, 3), 1'b0,
                    0, 4'h0, 1'b0, 0, 4'h0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
